cache_fill_controller: RTL and testbench

CACHE_FILL_CONTROLLER -- requirements
Module: cache_fill_controller

---
 rtl/cache_fill_controller.sv | 151 +++++++++++++++
 tb/tb_cache_fill_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_controller.sv
// Refill sequencer shared by the I-cache and D-cache: fetches an 8-word block
// (16-bit words, 2-byte stride) from memory, writes it into the selected cache, then writes its tag.
module cache_fill_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_addr,
    input  logic        d_miss,
    input  logic [15:0] d_addr,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data_out,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        i_write_data_en,
    output logic        i_write_tag_en,
    output logic        d_write_data_en,
    output logic        d_write_tag_en,
    output logic        busy,
    output logic        fill_sel
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_TAG  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  issue_cnt_q, issue_cnt_d;
    logic        issue_done_q, issue_done_d;
    logic [3:0]  recv_cnt_q, recv_cnt_d;
    logic [15:0] base_q, base_d;
    logic        sel_q, sel_d;

    // State, counter and latched-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            issue_cnt_q  <= 3'd0;
            issue_done_q <= 1'b0;
            recv_cnt_q   <= 4'd0;
            base_q       <= 16'd0;
            sel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            issue_done_q <= issue_done_d;
            recv_cnt_q   <= recv_cnt_d;
            base_q       <= base_d;
            sel_q        <= sel_d;
        end
    end

    // Next-state and counter logic; issue and receive sides advance independently.
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        issue_done_d = issue_done_q;
        recv_cnt_d   = recv_cnt_q;
        base_d       = base_q;
        sel_d        = sel_q;
        case (state_q)
            ST_IDLE: begin
                issue_cnt_d  = 3'd0;
                issue_done_d = 1'b0;
                recv_cnt_d   = 4'd0;
                if (d_miss) begin
                    sel_d   = 1'b1;
                    base_d  = d_addr & 16'hFFF0;
                    state_d = ST_FILL;
                end else if (i_miss) begin
                    sel_d   = 1'b0;
                    base_d  = i_addr & 16'hFFF0;
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (!issue_done_q) begin
                    if (issue_cnt_q == 3'd7) begin
                        issue_done_d = 1'b1;
                    end else begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                    end
                end else begin
                    issue_cnt_d = issue_cnt_q;
                end
                if (mem_data_valid) begin
                    recv_cnt_d = recv_cnt_q + 4'd1;
                    if (recv_cnt_q == 4'd7) begin
                        state_d = ST_TAG;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    recv_cnt_d = recv_cnt_q;
                end
            end
            ST_TAG: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs; cache writes follow mem_data_valid in the same cycle.
    always_comb begin
        mem_en          = 1'b0;
        mem_addr        = 16'd0;
        fill_addr       = 16'd0;
        fill_data       = 16'd0;
        i_write_data_en = 1'b0;
        i_write_tag_en  = 1'b0;
        d_write_data_en = 1'b0;
        d_write_tag_en  = 1'b0;
        busy            = (state_q != ST_IDLE);
        fill_sel        = sel_q;
        case (state_q)
            ST_FILL: begin
                if (!issue_done_q) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + {12'd0, issue_cnt_q, 1'b0};
                end else begin
                    mem_en   = 1'b0;
                end
                if (mem_data_valid) begin
                    fill_addr       = base_q + {11'd0, recv_cnt_q, 1'b0};
                    fill_data       = mem_data_out;
                    d_write_data_en = sel_q;
                    i_write_data_en = ~sel_q;
                end else begin
                    fill_addr = 16'd0;
                end
            end
            ST_TAG: begin
                fill_addr      = base_q;
                d_write_tag_en = sel_q;
                i_write_tag_en = ~sel_q;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Directed bench for cache_fill_controller: behavioural memory with a programmable
// latency, scoreboard queues for issues, data writes and tag writes.
module tb_cache_fill_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss = 1'b0;
    logic [15:0] i_addr = 16'd0;
    logic        d_miss = 1'b0;
    logic [15:0] d_addr = 16'd0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data_out = 16'd0;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        i_write_data_en;
    logic        i_write_tag_en;
    logic        d_write_data_en;
    logic        d_write_tag_en;
    logic        busy;
    logic        fill_sel;

    cache_fill_controller dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .mem_data_out(mem_data_out),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .i_write_data_en(i_write_data_en), .i_write_tag_en(i_write_tag_en),
        .d_write_data_en(d_write_data_en), .d_write_tag_en(d_write_tag_en),
        .busy(busy), .fill_sel(fill_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic        sel;
        logic [15:0] addr;
    } rd_t;

    exp_t issue_q[$];
    exp_t wr_q[$];
    exp_t tag_q[$];
    rd_t  mem_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lat = 4;
    int   issue_n = 0;
    int   last_issue_cyc = 0;
    int   first_issue_cyc = 0;
    int   tag_cyc = 0;
    int   data_wr_cnt = 0;
    int   tag_wr_cnt = 0;
    logic obs_busy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_fill(input logic sel, input logic [15:0] addr);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            issue_q.push_back('{sel: sel, addr: base + 16'(2 * k), data: 16'd0});
        end
        tag_q.push_back('{sel: sel, addr: base, data: 16'd0});
    endtask

    // Observe one cycle at the falling edge, then advance and drive the memory return.
    task automatic step();
        exp_t e;
        rd_t  r;
        logic onehot_ok;
        @(negedge clk);
        obs_busy  = busy;
        onehot_ok = ($countones({i_write_data_en, i_write_tag_en,
                                 d_write_data_en, d_write_tag_en}) <= 1);
        chk("strobe_onehot", 64'(onehot_ok), 64'd1);
        if (!busy) issue_n = 0;
        if (mem_en) begin
            if (issue_q.size() == 0) begin
                chk("unexpected_issue", 64'(mem_addr), 64'hFFFF_FFFF);
            end else begin
                e = issue_q.pop_front();
                chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                chk("fill_sel", 64'(fill_sel), 64'(e.sel));
                if (issue_n > 0) chk("issue_consecutive", 64'(cyc), 64'(last_issue_cyc + 1));
                else first_issue_cyc = cyc;
                issue_n++;
                last_issue_cyc = cyc;
                mem_q.push_back('{due: cyc + lat, sel: e.sel, addr: e.addr});
            end
        end
        if (i_write_data_en || d_write_data_en) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_data_wr", 64'(fill_addr), 64'hFFFF_FFFF);
            end else begin
                e = wr_q.pop_front();
                chk("wr_sel", 64'(d_write_data_en), 64'(e.sel));
                chk("fill_addr", 64'(fill_addr), 64'(e.addr));
                chk("fill_data", 64'(fill_data), 64'(e.data));
                data_wr_cnt++;
            end
        end else if (i_write_tag_en || d_write_tag_en) begin
            if (tag_q.size() == 0) begin
                chk("unexpected_tag_wr", 64'(fill_addr), 64'hFFFF_FFFF);
            end else begin
                e = tag_q.pop_front();
                chk("tag_sel", 64'(d_write_tag_en), 64'(e.sel));
                chk("tag_addr", 64'(fill_addr), 64'(e.addr));
                tag_wr_cnt++;
                tag_cyc = cyc;
            end
        end else begin
            chk("idle_fill_zero", {32'd0, fill_addr, fill_data}, 64'd0);
        end
        @(posedge clk);
        cyc++;
        #1;
        mem_data_valid = 1'b0;
        mem_data_out   = 16'd0;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            r = mem_q.pop_front();
            mem_data_valid = 1'b1;
            mem_data_out   = r.addr ^ 16'hC3A5;
            wr_q.push_back('{sel: r.sel, addr: r.addr, data: r.addr ^ 16'hC3A5});
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {10'd0, busy, mem_en, i_write_data_en, i_write_tag_en, d_write_data_en,
                  d_write_tag_en, mem_addr, fill_addr, fill_data}, 64'd0);
    endtask

    task automatic run_until_idle(input int max);
        logic seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        while (n < max) begin
            step();
            n++;
            if (seen && !obs_busy) break;
            seen = seen | obs_busy;
        end
        if (n >= max) chk("timeout_idle", 64'(n), 64'(0));
    endtask

    task automatic single_fill(input int l, input logic [15:0] addr);
        lat = l;
        data_wr_cnt = 0;
        tag_wr_cnt  = 0;
        i_addr = addr;
        expect_fill(1'b0, addr);
        i_miss = 1'b1;
        step();
        step();
        i_miss = 1'b0;
        run_until_idle(100);
        chk("data_wr_count", 64'(data_wr_cnt), 64'd8);
        chk("tag_wr_count", 64'(tag_wr_cnt), 64'd1);
        chk("queues_drained", 64'(issue_q.size() + wr_q.size() + tag_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset_outputs");
        rst_n = 1'b1;
        step();
        chk("idle_busy", 64'(obs_busy), 64'd0);

        // I-miss only, latency 4; i_miss drops mid-fill
        single_fill(4, 16'h1234);

        // Simultaneous misses: D first, I starts right after the D tag cycle
        lat = 4;
        data_wr_cnt = 0;
        tag_wr_cnt  = 0;
        i_addr = 16'h1234;
        d_addr = 16'h5432;
        expect_fill(1'b1, 16'h5432);
        expect_fill(1'b0, 16'h1234);
        i_miss = 1'b1;
        d_miss = 1'b1;
        step();
        step();
        d_miss = 1'b0;
        n = 0;
        while (tag_wr_cnt < 1 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("timeout_d_tag", 64'(n), 64'd0);
        step();
        chk("idle_after_d_tag", 64'(obs_busy), 64'd0);
        step();
        chk("i_fill_start", 64'(first_issue_cyc), 64'(tag_cyc + 2));
        i_miss = 1'b0;
        run_until_idle(100);
        chk("both_data_wr_count", 64'(data_wr_cnt), 64'd16);
        chk("both_tag_wr_count", 64'(tag_wr_cnt), 64'd2);

        // Latency extremes
        single_fill(1, 16'h0ABC);
        single_fill(10, 16'hFFFF);

        // Reset after the 3rd returned word
        lat = 4;
        data_wr_cnt = 0;
        tag_wr_cnt  = 0;
        i_addr = 16'h9ABC;
        expect_fill(1'b0, 16'h9ABC);
        i_miss = 1'b1;
        n = 0;
        while (data_wr_cnt < 3 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("timeout_third_word", 64'(n), 64'd0);
        i_miss = 1'b0;
        mem_data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_quiet("reset_midfill_outputs");
        issue_q.delete();
        wr_q.delete();
        tag_q.delete();
        mem_q.delete();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_data_valid = 1'b1;
            mem_data_out   = 16'hDEAD;
            step();
            chk("spurious_valid_busy", 64'(obs_busy), 64'd0);
        end
        chk("reset_no_tag", 64'(tag_wr_cnt), 64'd0);
        chk("reset_data_count", 64'(data_wr_cnt), 64'd3);

        // Valid pulses in IDLE with no miss pending
        for (int k = 0; k < 3; k++) begin
            mem_data_valid = 1'b1;
            mem_data_out   = 16'h5A5A;
            step();
            chk("idle_valid_busy", 64'(obs_busy), 64'd0);
        end
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
